// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: owns the PC and issues one held req/ack fetch at a time.
// Fetched words are buffered with their PCs in a prefetch FIFO drained by decode.
// Optional: define INSTRUCTION_FETCH_QUEUE_PERF_EN to add fetch/stall counters.
module instruction_fetch_queue #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            INSTR_WIDTH = 16,
  parameter int unsigned            FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         redirect_i,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc_i,
  output logic                         imem_req_o,
  output logic [ADDR_WIDTH-1:0]        imem_addr_o,
  input  logic                         imem_ack_i,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [INSTR_WIDTH-1:0]       instr_o,
  output logic [ADDR_WIDTH-1:0]        instr_pc_o,
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  output logic [31:0]                  perf_fetch_cnt_o,
  output logic [31:0]                  perf_stall_cnt_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);

  localparam int unsigned PC_STEP   = INSTR_WIDTH / 8;
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned AlignBits = $clog2(PC_STEP);

  localparam logic [ADDR_WIDTH-1:0] Step      = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] AlignMask =
      ~((ADDR_WIDTH'(1) << AlignBits) - ADDR_WIDTH'(1));
  localparam logic [CntW-1:0]       DepthCnt  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic                    req_q;

  logic [INSTR_WIDTH-1:0]  data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [CntW-1:0]         count_q;

  logic                    valid;
  logic                    push, pop;
  logic [CntW-1:0]         count_after;
  logic [ADDR_WIDTH-1:0]   redir_pc;

  // Shared handshake/occupancy terms; redirect suppresses both push and pop.
  always_comb begin
    valid       = (count_q != '0);
    redir_pc    = redirect_pc_i & AlignMask;
    push        = (state_q == StReq) && imem_ack_i && !redirect_i;
    pop         = valid && instr_ready_i && !redirect_i;
    count_after = count_q + CntW'(push) - CntW'(pop);
  end

  // Fetch FSM: tracks PC, outstanding request address and the registered request strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      req_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect_i) begin
            state_q    <= StReq;
            req_addr_q <= redir_pc;
            fetch_pc_q <= redir_pc + Step;
            req_q      <= 1'b1;
          end else if (count_q < DepthCnt) begin
            state_q    <= StReq;
            req_addr_q <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + Step;
            req_q      <= 1'b1;
          end
        end
        StReq: begin
          if (redirect_i) begin
            if (imem_ack_i) begin
              // Returned data is stale; restart straight at the new PC.
              req_addr_q <= redir_pc;
              fetch_pc_q <= redir_pc + Step;
            end else begin
              // Request stays held until memory answers, then is dropped.
              state_q    <= StDiscard;
              fetch_pc_q <= redir_pc;
            end
          end else if (imem_ack_i) begin
            if (count_after < DepthCnt) begin
              req_addr_q <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + Step;
            end else begin
              state_q <= StIdle;
              req_q   <= 1'b0;
            end
          end
        end
        StDiscard: begin
          if (imem_ack_i) begin
            state_q <= StReq;
            if (redirect_i) begin
              req_addr_q <= redir_pc;
              fetch_pc_q <= redir_pc + Step;
            end else begin
              req_addr_q <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_q + Step;
            end
          end else if (redirect_i) begin
            fetch_pc_q <= redir_pc;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch FIFO storage and pointers; redirect flushes it.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        data_q[wptr_q] <= imem_rdata_i;
        pc_q[wptr_q]   <= req_addr_q;
        wptr_q         <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_after;
    end
  end

  // Head view reads zero when empty so decode never sees stale entries.
  always_comb begin
    imem_req_o    = req_q;
    imem_addr_o   = req_addr_q;
    instr_valid_o = valid;
    instr_o       = valid ? data_q[rptr_q] : '0;
    instr_pc_o    = valid ? pc_q[rptr_q] : '0;
    fifo_count_o  = count_q;
  end

`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  // Saturating performance counters, cleared on redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && (perf_fetch_q != '1)) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (instr_ready_i && !valid && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_instruction_fetch_queue;

  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned STEP  = IW / 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          redirect_i = 1'b0;
  logic [AW-1:0] redirect_pc_i = '0;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_ack_i = 1'b0;
  logic [IW-1:0] imem_rdata_i = '0;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic [IW-1:0] instr_o;
  logic [AW-1:0] instr_pc_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
  logic [31:0]   perf_fetch_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
`ifdef INSTRUCTION_FETCH_QUEUE_PERF_EN
    .perf_fetch_cnt_o(perf_fetch_cnt),
    .perf_stall_cnt_o(perf_stall_cnt),
`endif
    .fifo_count_o (fifo_count_o)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] data;
  } entry_t;

  // Reference model: delivered instructions as a queue plus the next PC to fetch.
  entry_t        q[$];
  logic [AW-1:0] next_fetch;
  bit            discard_pending;
  bit            exp_req;
  bit            hold_chk;
  logic [AW-1:0] hold_addr;
  bit            model_live = 1'b0;
  bit            after_reset;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Memory contents: a fixed scramble of the address so data is tied to its PC.
  function automatic logic [IW-1:0] mem_f(input logic [AW-1:0] a);
    return (a[15:0] * 16'h9E37) ^ a[31:16] ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input bit r, input bit rd, input logic [AW-1:0] tgt,
                       input bit ak, input bit rdy);
    int unsigned sz0;
    bit          hs;
    bit          pop;
    if (model_live) begin
      check("req", 48'(imem_req_o), 48'(exp_req));
      check("count", 48'(fifo_count_o), 48'(q.size()));
      check("valid", 48'(instr_valid_o), 48'(q.size() != 0));
      check("instr", 48'(instr_o), (q.size() != 0) ? 48'(q[0].data) : 48'h0);
      check("instr_pc", 48'(instr_pc_o), (q.size() != 0) ? 48'(q[0].pc) : 48'h0);
      if (hold_chk) check("addr_hold", 48'(imem_addr_o), 48'(hold_addr));
      if (after_reset) check("reset_addr", 48'(imem_addr_o), 48'h0);
    end
    rst_i         = r;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    imem_ack_i    = ak;
    imem_rdata_i  = mem_f(imem_addr_o);
    instr_ready_i = rdy;
    hold_chk      = 1'b0;
    after_reset   = 1'b0;
    if (r) begin
      q.delete();
      next_fetch      = 32'h0;
      discard_pending = 1'b0;
      exp_req         = 1'b0;
      model_live      = 1'b1;
      after_reset     = 1'b1;
    end else if (model_live) begin
      sz0 = q.size();
      hs  = exp_req && ak;
      pop = (sz0 != 0) && rdy && !rd;
      if (rd) begin
        q.delete();
        next_fetch      = tgt & ~32'(STEP - 1);
        discard_pending = exp_req && !ak;
        exp_req         = 1'b1;
        if (discard_pending) begin
          hold_chk  = 1'b1;
          hold_addr = imem_addr_o;
        end
      end else begin
        if (pop) void'(q.pop_front());
        if (hs) begin
          if (discard_pending) begin
            discard_pending = 1'b0;
            exp_req         = 1'b1;
          end else begin
            check("fetch_addr", 48'(imem_addr_o), 48'(next_fetch));
            q.push_back({next_fetch, mem_f(next_fetch)});
            next_fetch = next_fetch + AW'(STEP);
            exp_req    = (q.size() < DEPTH);
          end
        end else if (exp_req) begin
          hold_chk  = 1'b1;
          hold_addr = imem_addr_o;
        end else begin
          exp_req = (sz0 < DEPTH);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 1);
    // Streaming: ready decoder, memory acks every request immediately.
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);
    // Decoder stalled: FIFO fills to DEPTH, fetch stops, then restarts on pop.
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1, 0);
    check("full_req_low", 48'(imem_req_o), 48'h0);
    check("full_count", 48'(fifo_count_o), 48'(DEPTH));
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1);
    // Slow memory: request held for three cycles before ack.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // Redirect to an unaligned PC while a request is pending without ack.
    cycle(0, 1, 32'h101, 0, 0);
    check("redir_empty", 48'(fifo_count_o), 48'h0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("redir_addr", 48'(imem_addr_o), 48'h100);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);
    // Redirect coincident with an ack and a pop.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 32'h2000, 1, 1);
    check("redir_ack_count", 48'(fifo_count_o), 48'h0);
    check("redir_ack_addr", 48'(imem_addr_o), 48'h2000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);
    // PC wrap at the top of the address space.
    cycle(0, 1, 32'hFFFF_FFFF, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    check("wrap_addr", 48'(imem_addr_o), 48'h0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1);
    // Reset mid-request, then a stray ack once idle.
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1);
    // Random traffic with varying memory and decoder rates.
    for (int i = 0; i < 3000; i++) begin
      int unsigned ack_rate;
      int unsigned rdy_rate;
      ack_rate = 1 + (i / 500) % 4;
      rdy_rate = 1 + (i / 700) % 4;
      cycle(($urandom % 300) == 0,
            ($urandom % 23) == 0,
            $urandom,
            ($urandom % ack_rate) == 0,
            ($urandom % rdy_rate) == 0);
    end
    cycle(0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
